// File: rtl/alu_pkg.sv
// Shared constants, FSM state type and helpers for the execute-stage ALU
// controller and its iterative multiply/divide engine.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [3:0] FUNCT_MUL = 4'h1;
  localparam logic [3:0] FUNCT_DIV = 4'h2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Unsigned magnitude of a two's-complement value. -32768 maps to 16'h8000,
  // which is the correct unsigned magnitude.
  function automatic logic [ALU_WIDTH-1:0] mag(input logic [ALU_WIDTH-1:0] x);
    return x[ALU_WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned multiply / restoring divide engine with sign fixup.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clear          abort: drop all partial state
//   start          latch operands and begin 16 iterations
//   op_div         1 = divide, 0 = multiply (sampled on start)
//   a, b           signed operands (sampled on start)
//   last_step      high during the cycle that performs iteration 15
//   lo, hi         sign-corrected product low/high or quotient/remainder
module muldiv_core
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 op_div,
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  output logic                 last_step,
  output logic [ALU_WIDTH-1:0] lo,
  output logic [ALU_WIDTH-1:0] hi
);

  // acc[31:16] = partial product high / remainder,
  // acc[15:0]  = multiplier bits / dividend-then-quotient bits.
  logic [31:0] acc, acc_step, prod;
  logic [15:0] dvs, rem_new;
  logic [3:0]  count;
  logic        running, is_div, neg_lo, neg_hi, div0, ge;
  logic [16:0] mul_sum;

  always_comb begin
    mul_sum = {1'b0, acc[31:16]} + (acc[0] ? {1'b0, dvs} : 17'd0);
    // The remainder is always below the divisor (<= 16'h8000), so acc[31]
    // stays clear and the shifted remainder fits in 16 bits.
    ge      = (acc[31:15] >= {1'b0, dvs});
    rem_new = ge ? (acc[30:15] - dvs) : acc[30:15];
    if (is_div) acc_step = {rem_new, acc[14:0], ge};
    else        acc_step = {mul_sum, acc[15:1]};
  end

  always_comb begin
    prod = neg_lo ? (~acc + 32'd1) : acc;
    if (is_div) begin
      // Divide by zero leaves the dividend magnitude as remainder, so the
      // sign-corrected remainder is the original dividend.
      lo = div0   ? 16'hFFFF : (neg_lo ? (~acc[15:0] + 16'd1) : acc[15:0]);
      hi = neg_hi ? (~acc[31:16] + 16'd1) : acc[31:16];
    end else begin
      lo = prod[15:0];
      hi = prod[31:16];
    end
  end

  assign last_step = running && (count == 4'd15);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc     <= '0;
      dvs     <= '0;
      count   <= '0;
      running <= 1'b0;
      is_div  <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      div0    <= 1'b0;
    end else if (start) begin
      acc     <= {16'd0, mag(a)};
      dvs     <= mag(b);
      count   <= '0;
      running <= 1'b1;
      is_div  <= op_div;
      neg_lo  <= a[15] ^ b[15];
      // Remainder follows the dividend's sign.
      neg_hi  <= op_div ? a[15] : (a[15] ^ b[15]);
      div0    <= op_div && (b == '0);
    end else if (running) begin
      acc   <= acc_step;
      count <= count + 4'd1;
      if (count == 4'd15) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage controller: issues single-cycle ops to the external ALU and
// sequences multi-cycle signed multiply/divide through muldiv_core.
// Ports:
//   clk, rst, flush                  clock, sync active-high reset, abort
//   in_valid/in_ready, in_funct,
//   in_a, in_b, in_tag               decode-side handshake and operands
//   alu_funct, alu_a, alu_b,
//   alu_result, alu_branch           combinational ALU interface
//   out_valid/out_ready, out_result,
//   out_r0, out_r0_we, out_branch,
//   out_tag                          writeback-side handshake and results
//   busy                             controller not in IDLE
//
// state | meaning
// IDLE  | accepting ops; single-cycle ops complete here
// ITER  | 16 multiply/divide iterations in progress
// FIX   | sign correction, result loaded into output register
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_funct,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAGW-1:0]  in_tag,
  output logic [3:0]       alu_funct,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_branch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_r0,
  output logic             out_r0_we,
  output logic             out_branch,
  output logic [TAGW-1:0]  out_tag,
  output logic             busy
);

  state_t          state, state_next;
  logic            is_md, accept, start, last_step;
  logic [WIDTH-1:0] md_lo, md_hi;
  logic [TAGW-1:0] tag_q;

  assign is_md    = (in_funct == FUNCT_MUL) || (in_funct == FUNCT_DIV);
  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign start    = accept && is_md;
  assign busy     = (state != IDLE);

  muldiv_core u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .start     (start),
    .op_div    (in_funct == FUNCT_DIV),
    .a         (in_a),
    .b         (in_b),
    .last_step (last_step),
    .lo        (md_lo),
    .hi        (md_hi)
  );

  always_comb begin
    state_next = state;
    alu_funct  = 4'h0;
    alu_a      = '0;
    alu_b      = '0;
    case (state)
      IDLE: begin
        alu_funct = in_funct;
        alu_a     = in_a;
        alu_b     = in_b;
        if (start) state_next = ITER;
      end
      ITER:    if (last_step) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst)        tag_q <= '0;
    else if (start) tag_q <= in_tag;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_r0     <= '0;
      out_r0_we  <= 1'b0;
      out_branch <= 1'b0;
      out_tag    <= '0;
    end else if (accept && !is_md) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_r0     <= '0;
      out_r0_we  <= 1'b0;
      out_branch <= alu_branch;
      out_tag    <= in_tag;
    end else if (state == FIX) begin
      out_valid  <= 1'b1;
      out_result <= md_lo;
      out_r0     <= md_hi;
      out_r0_we  <= 1'b1;
      out_branch <= 1'b0;
      out_tag    <= tag_q;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_r0     <= '0;
      out_r0_we  <= 1'b0;
      out_branch <= 1'b0;
      out_tag    <= '0;
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Execute-stage controller for the 16-bit CPU pipeline ALU. It accepts one operation at a time from decode through a valid/ready handshake. Single-cycle functs go to the combinational ALU and are registered. Signed multiply (funct 4'h1) and signed divide (funct 4'h2) run as a 16-iteration shift/add or restoring sequence with stall back-pressure. Results, the R0 side result and the branch flag are presented to writeback through a second valid/ready handshake.

## Interface
- `WIDTH`, 16, operand/result width; only 16 is supported.
- `TAGW`, 4, destination-tag width, carried through unchanged.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  abort in-flight op and drop pending output
- `in_valid`  in  1  decode presents an op
- `in_ready`  out  1  op accepted when `in_valid & in_ready`
- `in_funct`  in  4  ALU function code
- `in_a`, `in_b`  in  WIDTH  signed operands (Rout1, Rout2)
- `in_tag`  in  TAGW  destination tag
- `alu_funct`  out  4  to ALU
- `alu_a`, `alu_b`  out  WIDTH  to ALU
- `alu_result`  in  WIDTH  ALU result (combinational)
- `alu_branch`  in  1  ALU branch flag
- `out_valid`  out  1  result available
- `out_ready`  in  1  writeback consumes when `out_valid & out_ready`
- `out_result`  out  WIDTH  result / product low / quotient
- `out_r0`  out  WIDTH  product high / remainder
- `out_r0_we`  out  1  high only for funct 4'h1 and 4'h2
- `out_branch`  out  1  registered `alu_branch`; 0 for mul/div
- `out_tag`  out  TAGW  tag of the op
- `busy`  out  1  state is not IDLE

## Operation
- States are IDLE, ITER and FIX.
- `in_ready = (state==IDLE) & (~out_valid | out_ready) & ~flush`.
- Single-cycle funct (anything except 1 and 2):
  - `alu_*` is driven straight from `in_*` while in IDLE.
  - On accept, `alu_result` and `alu_branch` are registered into the output.
  - `out_r0_we=0` and `out_r0=0`.
- Mul/div accept:
  - Latch the operand magnitudes, the result sign and the tag.
  - Counter set to 0; go to ITER.
- ITER: one shift/add (MUL) or restoring subtract (DIV) step per cycle.
  - After the step with counter==15, go to FIX.
- FIX:
  - Apply two's-complement sign correction.
  - Load the output registers and set `out_valid`; go to IDLE.
- MUL: the 32-bit signed product is split as `out_result`=[15:0], `out_r0`=[31:16].
- DIV uses truncating division; the remainder takes the sign of the dividend.
  - Divide by zero: `out_result`=16'hFFFF, `out_r0`=`in_a`; full latency still applies.
  - -32768 / -1: `out_result`=16'h8000, `out_r0`=0 (wraps).
- While outside IDLE, `alu_funct`, `alu_a` and `alu_b` hold 0.
- Output register:
  - Holds its value while `out_valid & ~out_ready`.
  - Cleared when it is consumed and nothing new is loaded.
- `flush`:
  - Forces IDLE, clears `out_valid` and the counter, and discards partial state.
  - Blocks accept in the same cycle.
- `rst` has priority over `flush`. All outputs reset to 0; state resets to IDLE.

## Timing
- Single-cycle op accepted at edge N: `out_valid`=1 after edge N+1 (latency 1).
  - Back-to-back issue every cycle is possible when `out_ready`=1.
- Mul/div accepted at edge N:
  - 16 ITER cycles, then 1 FIX cycle.
  - `out_valid` after edge N+17.
  - `in_ready`=0 for cycles N+1 through N+17.
- Output stall: while `out_valid & ~out_ready`, `in_ready`=0 and no op is accepted.
- Simultaneous consume and accept: allowed. The new result replaces the old one on the next edge; `out_valid` stays 1.
- Reset asserted mid-ITER: on the next edge, state=IDLE, `out_valid`=0, `busy`=0. A new op is accepted in the first cycle after `rst` deasserts.

## Structure
- Package `alu_pkg` holds:
  - `ALU_WIDTH`=16
  - `FUNCT_MUL`=4'h1, `FUNCT_DIV`=4'h2
  - the state enum {IDLE, ITER, FIX}
- Sub-module `muldiv_core` holds:
  - the iterative unsigned engine: accumulator, counter, start/done
  - its sign fixup inputs
- The top level keeps the handshake, the output register and flush/reset priority.

## Test plan
- Single-cycle op: funct 4'hE, a=-5, b=2 with `out_ready`=1.
  - `alu_*` mirror the inputs.
  - `out_valid` 1 cycle later with `alu_result`.
  - `out_r0_we`=0.
- MUL: a=-5, b=2.
  - `out_valid` exactly 17 cycles after accept.
  - `out_result`=16'hFFF6, `out_r0`=16'hFFFF, `out_r0_we`=1.
  - `in_ready` low throughout.
- DIV cases:
  - a=5, b=4 → result 0001, R0 0001.
  - a=-7, b=2 → result FFFD, R0 FFFF.
  - a=5, b=0 → result FFFF, R0 0005.
  - a=8000, b=FFFF → result 8000, R0 0000.
- Back-pressure: hold `out_ready`=0 for 5 cycles after a result.
  - Outputs stay stable and `in_ready`=0.
  - Then raise `out_ready` together with a new `in_valid`: the new result appears on the next edge.
- `flush` or `rst` at ITER count 7 of a MUL:
  - Next cycle: IDLE, `out_valid`=0, no result emitted.
  - A following 4'hC op completes with latency 1.
